// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// helper that sizes the bit counter.
package serial_adder_pkg;

  // Controller states; encodings are fixed so other blocks can decode them.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the bit counter: ceil(log2(width)), never less than one bit so
  // a single-bit adder still has a legal counter register.
  function automatic int count_width(input int width);
    int w;
    w = 0;
    while ((1 << w) < width) begin
      w = w + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle between a datapath controller (master) and the
// bit-serial adder (slave).
interface serial_adder_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/full_adder.sv
// Single-bit full adder cell: s = a ^ b ^ cin, cout = majority(a, b, cin).
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic cout,
  output logic s
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder. Operands are captured on an accepted start,
// shifted LSB-first through one full_adder cell (carry held in a flop between
// bits), and the parallel sum/carry-out are presented with a one-cycle done.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst_n,
  serial_adder_if.slave bus
);

  localparam int CW = count_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state_reg;
  logic [WIDTH-1:0] a_sr_reg;
  logic [WIDTH-1:0] b_sr_reg;
  logic [WIDTH-1:0] sum_sr_reg;
  logic [WIDTH-1:0] sum_reg;
  logic [CW-1:0]    count_reg;
  logic             carry_reg;
  logic             cout_reg;
  logic             busy_reg;
  logic             done_reg;

  logic             fa_s;
  logic             fa_cout;
  logic [WIDTH-1:0] sum_sr_next;

  // One bit of the addition per clock: current LSBs plus the held carry.
  full_adder u_full_adder (
    .a    (a_sr_reg[0]),
    .b    (b_sr_reg[0]),
    .cin  (carry_reg),
    .cout (fa_cout),
    .s    (fa_s)
  );

  // New sum bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
  // Written as a shift of the concatenation so it also holds for WIDTH=1.
  assign sum_sr_next = WIDTH'({fa_s, sum_sr_reg} >> 1);

  // Controller, shift registers, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      a_sr_reg   <= '0;
      b_sr_reg   <= '0;
      sum_sr_reg <= '0;
      sum_reg    <= '0;
      count_reg  <= '0;
      carry_reg  <= 1'b0;
      cout_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            a_sr_reg  <= bus.a;
            b_sr_reg  <= bus.b;
            carry_reg <= bus.cin;
            count_reg <= '0;
            busy_reg  <= 1'b1;
            state_reg <= RUN;
          end
        end
        RUN: begin
          sum_sr_reg <= sum_sr_next;
          a_sr_reg   <= a_sr_reg >> 1;
          b_sr_reg   <= b_sr_reg >> 1;
          carry_reg  <= fa_cout;
          count_reg  <= count_reg + 1'b1;
          if (count_reg == LAST_BIT) begin
            // Result registers load with the final bit so they are valid
            // in the same cycle done is high; they hold until the next result.
            sum_reg   <= sum_sr_next;
            cout_reg  <= fa_cout;
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.sum  = sum_reg;
  assign bus.cout = cout_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomized checks of the bit-serial adder at WIDTH=8 and
// WIDTH=1 against plain integer addition.
module tb_serial_adder;

  logic clk;
  logic rst_n;

  int n_cmp;
  int n_mis;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(1)) bus1 ();

  serial_adder #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=8 addition; operands are scrambled right after the accepted
  // start to show only the captured copies matter.
  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic cv, input string tag);
    logic [8:0] expv;
    int n;
    bit seen;
    expv = 9'(av) + 9'(bv) + 9'(cv);
    @(negedge clk);
    bus8.a = av; bus8.b = bv; bus8.cin = cv; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0; bus8.a = 8'h11; bus8.b = 8'h11; bus8.cin = ~cv;
    check({tag, " busy"}, 32'(bus8.busy), 32'd1);
    n = 2;
    seen = 1'b0;
    while (!seen && n < 40) begin
      if (bus8.done) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        n++;
      end
    end
    check({tag, " done seen"}, 32'(seen), 32'd1);
    check({tag, " latency"}, 32'(n), 32'd10);
    check({tag, " sum"}, 32'(bus8.sum), 32'(expv[7:0]));
    check({tag, " cout"}, 32'(bus8.cout), 32'(expv[8]));
    $display("op8 %s: a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d cycles=%0d",
             tag, av, bv, cv, bus8.sum, bus8.cout, n);
    @(posedge clk); #1;
    check({tag, " done pulse"}, 32'(bus8.done), 32'd0);
  endtask

  // One WIDTH=1 addition.
  task automatic run1(input logic av, input logic bv, input logic cv);
    logic [1:0] expv;
    int n;
    bit seen;
    string tag;
    tag = $sformatf("w1 %0d%0d%0d", av, bv, cv);
    expv = 2'(av) + 2'(bv) + 2'(cv);
    @(negedge clk);
    bus1.a = av; bus1.b = bv; bus1.cin = cv; bus1.start = 1'b1;
    @(posedge clk); #1;
    bus1.start = 1'b0;
    n = 2;
    seen = 1'b0;
    while (!seen && n < 20) begin
      if (bus1.done) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        n++;
      end
    end
    check({tag, " done seen"}, 32'(seen), 32'd1);
    check({tag, " latency"}, 32'(n), 32'd3);
    check({tag, " sum"}, 32'(bus1.sum), 32'(expv[0]));
    check({tag, " cout"}, 32'(bus1.cout), 32'(expv[1]));
    $display("op1 a=%0d b=%0d cin=%0d -> sum=%0d cout=%0d cycles=%0d",
             av, bv, cv, bus1.sum, bus1.cout, n);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;
    logic [8:0] expv;
    int dones;
    int first_done;
    int last_done;
    int gap_bad;

    n_cmp = 0;
    n_mis = 0;
    rst_n = 1'b0;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;

    // Reset state.
    #23;
    check("reset busy", 32'(bus8.busy), 32'd0);
    check("reset done", 32'(bus8.done), 32'd0);
    check("reset sum", 32'(bus8.sum), 32'd0);
    check("reset cout", 32'(bus8.cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed operations.
    run8(8'h00, 8'h00, 1'b0, "zero");
    run8(8'hFF, 8'h01, 1'b0, "wrap");
    run8(8'h3C, 8'h0F, 1'b0, "plain");
    run8(8'hA5, 8'h5A, 1'b1, "allcarry");

    // Start pulses while in RUN and in DONE are ignored.
    expv = 9'h05A + 9'h033 + 9'h001;
    @(negedge clk);
    bus8.a = 8'h5A; bus8.b = 8'h33; bus8.cin = 1'b1; bus8.start = 1'b1;
    dones = 0;
    for (int k = 0; k < 22; k++) begin
      @(posedge clk); #1;
      if (bus8.done) dones++;
      @(negedge clk);
      bus8.start = (k == 3 || k == 8);
    end
    check("ignore start dones", 32'(dones), 32'd1);
    check("ignore start sum", 32'(bus8.sum), 32'(expv[7:0]));
    check("ignore start cout", 32'(bus8.cout), 32'(expv[8]));
    check("ignore start idle", 32'(bus8.busy), 32'd0);
    $display("ignore-start: dones=%0d sum=%02h cout=%0d", dones, bus8.sum, bus8.cout);

    // Start held high: one result every WIDTH+2 cycles.
    expv = 9'h0C3 + 9'h07E;
    @(negedge clk);
    bus8.a = 8'hC3; bus8.b = 8'h7E; bus8.cin = 1'b0; bus8.start = 1'b1;
    dones = 0; first_done = -1; last_done = -1; gap_bad = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (bus8.done) begin
        if (last_done >= 0 && (k - last_done) != 10) gap_bad++;
        if (first_done < 0) first_done = k;
        last_done = k;
        dones++;
      end
      if (k == 29) begin
        @(negedge clk);
        bus8.start = 1'b0;
      end
    end
    check("held dones", 32'(dones), 32'd3);
    check("held first done", 32'(first_done), 32'd8);
    check("held gaps", 32'(gap_bad), 32'd0);
    check("held sum", 32'(bus8.sum), 32'(expv[7:0]));
    check("held cout", 32'(bus8.cout), 32'(expv[8]));
    $display("held-start: dones=%0d first=%0d sum=%02h cout=%0d", dones, first_done, bus8.sum, bus8.cout);
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Asynchronous reset in the middle of RUN (count=4).
    @(negedge clk);
    bus8.a = 8'h77; bus8.b = 8'h99; bus8.cin = 1'b1; bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst busy", 32'(bus8.busy), 32'd0);
    check("async rst done", 32'(bus8.done), 32'd0);
    check("async rst sum", 32'(bus8.sum), 32'd0);
    check("async rst cout", 32'(bus8.cout), 32'd0);
    $display("async-reset: busy=%0d done=%0d sum=%02h cout=%0d", bus8.busy, bus8.done, bus8.sum, bus8.cout);
    @(posedge clk); #1;
    check("rst held no done", 32'(bus8.done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run8(8'h80, 8'h80, 1'b0, "after rst");

    // Randomized operands against integer addition.
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      run8(ra, rb, rc, $sformatf("rand%0d", i));
    end

    // WIDTH=1 instance: full truth table.
    for (int i = 0; i < 8; i++) begin
      run1(i[2], i[1], i[0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
